lgdst_ts2spi_tx: RTL and testbench
==================================

Name: lgdst_ts2spi_tx

Overview:
- Transmit-direction companion of the receive glue, for the opposite data flow: it streams MPEG-TS packets from the demodulator back to the host over SPI.
- The host is the SPI master and drives spi_clk/spi_cs. Each CS-low frame reads one status byte followed by exactly one 188-byte TS packet on spi_miso.
- The upstream byte source is an async FIFO outside this block. Its read side is already in the spi_clk domain.

Parameters:
- PKT_LEN, 188, TS packet bytes per frame (8..255).
- SYNC_BYTE, 8'h47, required first packet byte.
- PAD_BYTE, 8'hFF, byte sent on underrun or while hunting.
- CNT_W, 16, width of pkt_cnt.

Ports:
- reset  in  1  async, active-low
- spi_clk  in  1  host SPI clock; only toggles while spi_cs low
- spi_cs  in  1  active-low frame select; rising edge asynchronously aborts the frame
- spi_miso  out  1  serial data, MSB first
- spi_miso_oe  out  1  1 while spi_cs low and reset high
- ts_byte  in  8  upstream byte
- ts_byte_sop  in  1  ts_byte is packet start
- ts_byte_vld  in  1  ts_byte/sop valid
- ts_byte_rdy  out  1  pop strobe, sampled by upstream on posedge spi_clk
- pkt_cnt  out  CNT_W  complete packets sent; wraps
- underrun  out  1  sticky
- sync_err  out  1  sticky
- abort  out  1  sticky; frame ended early

Behaviour:
- Interface decision: reset is asynchronous, active-low; the clock is spi_clk.
- SPI mode 0:
  - miso launches on negedge spi_clk; host samples on posedge.
  - First bit (status[7]) is valid from spi_cs fall. Before any edge, spi_miso is a combinational mux of the current byte indexed by bit_cnt.
- Counters, all on negedge spi_clk, asynchronously cleared by reset low or spi_cs high:
  - bit_cnt[2:0] increments each edge.
  - byte_cnt[7:0] increments when bit_cnt wraps 7->0.
  - byte_cnt range is 0..PKT_LEN. Edges beyond PKT_LEN*8+8 bits return to byte 0 of a new frame; byte_cnt does not hold.
- Status byte (byte 0) = {underrun, sync_err, abort, ts_byte_vld, pkt_cnt[3:0]}.
  - Snapshot taken at the frame's first posedge.
  - Sticky flags clear at that same posedge: reported once, then cleared. A set event in the same cycle wins.
- Fetch: at posedge with bit_cnt==7, the next byte loads into data_reg.
  - ts_byte_rdy is combinational: asserted when the fetch condition holds and ts_byte_vld=1 (one pop per byte slot).
- State machine, posedge spi_clk:
  - IDLE -> HDR at the byte-0 fetch.
  - HDR (fetch of packet byte 1):
    - vld & sop & byte==SYNC_BYTE -> DATA.
    - vld but fails check -> byte is sent anyway, sync_err set, -> DATA.
    - !vld -> PAD_BYTE, underrun set, -> PAD.
  - DATA: pops bytes.
    - !vld at a fetch -> PAD_BYTE, underrun, -> PAD.
    - sop seen mid-packet -> sync_err; the byte is still sent.
  - PAD: sends PAD_BYTE with no pops until byte_cnt==PKT_LEN.
  - At the last bit of byte PKT_LEN -> IDLE. pkt_cnt increments only if the frame ended from DATA (no padding, no abort).
- Abort: spi_cs rising before byte_cnt==PKT_LEN with bit_cnt==7 completed:
  - FSM -> IDLE asynchronously; abort flag set; pkt_cnt unchanged.
  - Unpopped bytes remain upstream.
- Reset values: spi_miso=0, spi_miso_oe=0, ts_byte_rdy=0, pkt_cnt=0, underrun=0, sync_err=0, abort=0, FSM=IDLE.

Optional Feature:
- Macro: TS_SYNC_CHECK_EN.
- Defined: in HDR, a vld byte that is not (sop & SYNC_BYTE) is popped and discarded.
  - Every posedge pops while vld & !sop (hunting); PAD_BYTE is sent meanwhile and sync_err is set.
  - On a valid sop+SYNC_BYTE, the byte is loaded at the next fetch slot -> DATA, and the frame still ends at PKT_LEN.
- Undefined: no discard; the byte is passed and sync_err is still flagged as above.

Decomposition:
- Package lgdst_ts_pkg:
  - TS_PKT_LEN=188, TS_SYNC=8'h47, TS_PAD=8'hFF.
  - FSM state encoding {IDLE, HDR, DATA, PAD}.
  - Status-byte bit positions.
- One sub-module: lgdst_spi_bitctr. It holds the negedge bit_cnt/byte_cnt with async CS/reset clear and outputs last_bit/frame_done.

Test Plan:
- Upstream holds a full packet (0x47, 0x01..0xBB) with sop on the first byte; 1512 host clocks -> miso returns status 0x10, then 0x47, 0x01..0xBB; pkt_cnt 0->1; no flags.
- Upstream empties after 100 bytes -> bytes 101..188 are 0xFF; next frame status[7]=1, then underrun clears; pkt_cnt unchanged.
- First byte 0x12 with sop=0:
  - Without the macro: 0x12 is output and sync_err is set.
  - With TS_SYNC_CHECK_EN: 3 junk bytes are popped, 0x47 packet follows, padding is 0xFF to byte 188.
- spi_cs deasserted after 50 bytes -> spi_miso_oe=0 immediately; abort sticky; next frame status[5]=1 and byte_cnt restarts at 0.
- Reset asserted mid-frame (byte 30) -> all outputs reach reset values asynchronously; after release and CS low, status byte=0x00 (vld=0 case).
- 16 back-to-back good frames -> pkt_cnt=16; status low nibble wraps to 0.

Source files
------------

// File: rtl/lgdst_ts_pkg.sv
// Shared types and constants for the TS-to-SPI transmit path.
// FSM encoding and status-byte layout used by lgdst_ts2spi_tx.
package lgdst_ts_pkg;

    localparam int         TS_PKT_LEN = 188;
    localparam logic [7:0] TS_SYNC    = 8'h47;
    localparam logic [7:0] TS_PAD     = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_PAD
    } ts_state_e;

    localparam int STS_UNDERRUN = 7;
    localparam int STS_SYNC_ERR = 6;
    localparam int STS_ABORT    = 5;
    localparam int STS_VLD      = 4;
    localparam int STS_CNT_W    = 4;

endpackage

// File: rtl/lgdst_spi_bitctr.sv
// Negedge bit/byte position counters for one SPI frame.
// Cleared asynchronously whenever the frame is not selected.
module lgdst_spi_bitctr
    import lgdst_ts_pkg::*;
#(
    parameter int PKT_LEN = TS_PKT_LEN
) (
    input  logic       spi_clk,
    input  logic       clr_n,
    output logic [2:0] bit_cnt,
    output logic [7:0] byte_cnt,
    output logic       last_bit,
    output logic       frame_done
);

    localparam logic [7:0] LAST_BYTE = 8'(PKT_LEN);

    assign last_bit   = (bit_cnt == 3'd7);
    assign frame_done = last_bit && (byte_cnt == LAST_BYTE);

    // Byte PKT_LEN is followed by the status byte of a new frame.
    always_ff @(negedge spi_clk or negedge clr_n) begin
        if (!clr_n) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
        end else begin
            bit_cnt <= bit_cnt + 3'd1;
            if (last_bit) begin
                byte_cnt <= (byte_cnt == LAST_BYTE) ? 8'd0 : byte_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/lgdst_ts2spi_tx.sv
// Streams one status byte plus one TS packet per CS-low SPI frame (mode 0).
// Define TS_SYNC_CHECK_EN to discard non-sync bytes while hunting for a header.
module lgdst_ts2spi_tx
    import lgdst_ts_pkg::*;
#(
    parameter int         PKT_LEN   = TS_PKT_LEN,
    parameter logic [7:0] SYNC_BYTE = TS_SYNC,
    parameter logic [7:0] PAD_BYTE  = TS_PAD,
    parameter int         CNT_W     = 16
) (
    input  logic             reset,
    input  logic             spi_clk,
    input  logic             spi_cs,
    output logic             spi_miso,
    output logic             spi_miso_oe,
    input  logic [7:0]       ts_byte,
    input  logic             ts_byte_sop,
    input  logic             ts_byte_vld,
    output logic             ts_byte_rdy,
    output logic [CNT_W-1:0] pkt_cnt,
    output logic             underrun,
    output logic             sync_err,
    output logic             abort
);

`ifdef TS_SYNC_CHECK_EN
    localparam bit HUNT = 1'b1;
`else
    localparam bit HUNT = 1'b0;
`endif

    localparam logic [7:0] LAST_BYTE = 8'(PKT_LEN);

    logic       clr_n;
    logic [2:0] bit_cnt;
    logic [7:0] byte_cnt;
    logic       last_bit;
    logic       frame_done;
    ts_state_e  state;
    logic [7:0] data_reg;
    logic [7:0] tx_reg;
    logic [7:0] status_reg;
    logic [7:0] status_live;
    logic [7:0] cur_byte;
    logic       first_edge;
    logic       fetch;
    logic       good_sop;
    logic       under_set;
    logic       sync_set;
    logic       abort_tgl;
    logic       abort_ack;

    assign clr_n       = reset & ~spi_cs;
    assign spi_miso_oe = clr_n;
    assign first_edge  = (byte_cnt == 8'd0) && (bit_cnt == 3'd0);
    assign fetch       = last_bit && (byte_cnt != LAST_BYTE);
    assign good_sop    = ts_byte_sop && (ts_byte == SYNC_BYTE);
    assign abort       = abort_tgl ^ abort_ack;

    lgdst_spi_bitctr #(
        .PKT_LEN(PKT_LEN)
    ) u_bitctr (
        .spi_clk   (spi_clk),
        .clr_n     (clr_n),
        .bit_cnt   (bit_cnt),
        .byte_cnt  (byte_cnt),
        .last_bit  (last_bit),
        .frame_done(frame_done)
    );

    always_comb begin
        status_live                  = '0;
        status_live[STS_UNDERRUN]    = underrun;
        status_live[STS_SYNC_ERR]    = sync_err;
        status_live[STS_ABORT]       = abort;
        status_live[STS_VLD]         = ts_byte_vld;
        status_live[STS_CNT_W-1:0]   = pkt_cnt[STS_CNT_W-1:0];
    end

    always_comb begin
        ts_byte_rdy = 1'b0;
        unique case (1'b1)
            (state == ST_HDR):
                ts_byte_rdy = ts_byte_vld && (fetch || (HUNT && !good_sop));
            (state == ST_DATA):
                ts_byte_rdy = ts_byte_vld && fetch;
            default: ts_byte_rdy = 1'b0;
        endcase
    end

    assign under_set = fetch && !ts_byte_vld
                    && (state == ST_HDR || state == ST_DATA);
    assign sync_set  = ts_byte_rdy
                    && ((state == ST_HDR) ? !good_sop : ts_byte_sop);

    // Status is live until the first posedge, then frozen for bits 6..0.
    always_comb begin
        cur_byte = tx_reg;
        if (byte_cnt == 8'd0) begin
            cur_byte = (state == ST_IDLE) ? status_live : status_reg;
        end
    end

    assign spi_miso = clr_n & cur_byte[~bit_cnt];

    always_ff @(negedge spi_clk or negedge clr_n) begin
        if (!clr_n) begin
            tx_reg <= '0;
        end else if (last_bit) begin
            tx_reg <= data_reg;
        end
    end

    always_ff @(posedge spi_clk or negedge clr_n) begin
        if (!clr_n) begin
            state      <= ST_IDLE;
            data_reg   <= PAD_BYTE;
            status_reg <= '0;
        end else begin
            if (first_edge) begin
                status_reg <= status_live;
            end
            if (frame_done) begin
                state <= ST_IDLE;
            end else begin
                unique case (state)
                    ST_IDLE: if (first_edge) state <= ST_HDR;
                    ST_HDR: if (fetch) begin
                        if (!ts_byte_vld) begin
                            data_reg <= PAD_BYTE;
                            state    <= ST_PAD;
                        end else if (HUNT && !good_sop) begin
                            data_reg <= PAD_BYTE;
                        end else begin
                            data_reg <= ts_byte;
                            state    <= ST_DATA;
                        end
                    end
                    ST_DATA: if (fetch) begin
                        if (ts_byte_vld) begin
                            data_reg <= ts_byte;
                        end else begin
                            data_reg <= PAD_BYTE;
                            state    <= ST_PAD;
                        end
                    end
                    ST_PAD: if (fetch) data_reg <= PAD_BYTE;
                endcase
            end
        end
    end

    always_ff @(posedge spi_clk or negedge reset) begin
        if (!reset) begin
            pkt_cnt   <= '0;
            underrun  <= 1'b0;
            sync_err  <= 1'b0;
            abort_ack <= 1'b0;
        end else begin
            if (first_edge) begin
                underrun  <= under_set;
                sync_err  <= sync_set;
                abort_ack <= abort_tgl;
            end else begin
                underrun <= underrun | under_set;
                sync_err <= sync_err | sync_set;
            end
            if (frame_done && state == ST_DATA) begin
                pkt_cnt <= pkt_cnt + CNT_W'(1);
            end
        end
    end

    // CS rising while a frame is in progress marks an abort.
    always_ff @(posedge spi_cs or negedge reset) begin
        if (!reset) begin
            abort_tgl <= 1'b0;
        end else if (state != ST_IDLE) begin
            abort_tgl <= ~abort_tgl;
        end
    end

endmodule

// File: tb/tb_lgdst_ts2spi_tx.sv
// Randomized bench for lgdst_ts2spi_tx with a byte-level frame model.
// Build with TS_SYNC_CHECK_EN to exercise header hunting.
module tb_lgdst_ts2spi_tx;
    import lgdst_ts_pkg::*;

    localparam int PL   = TS_PKT_LEN;
    localparam int FULL = 8 * (PL + 1);

    logic        reset;
    logic        spi_clk;
    logic        spi_cs;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic [7:0]  ts_byte;
    logic        ts_byte_sop;
    logic        ts_byte_vld;
    logic        ts_byte_rdy;
    logic [15:0] pkt_cnt;
    logic        underrun;
    logic        sync_err;
    logic        abort;

    lgdst_ts2spi_tx dut (
        .reset      (reset),
        .spi_clk    (spi_clk),
        .spi_cs     (spi_cs),
        .spi_miso   (spi_miso),
        .spi_miso_oe(spi_miso_oe),
        .ts_byte    (ts_byte),
        .ts_byte_sop(ts_byte_sop),
        .ts_byte_vld(ts_byte_vld),
        .ts_byte_rdy(ts_byte_rdy),
        .pkt_cnt    (pkt_cnt),
        .underrun   (underrun),
        .sync_err   (sync_err),
        .abort      (abort)
    );

    int checks = 0;
    int errors = 0;

    logic [8:0] q[$];
    logic       m_und, m_sync, m_abort;
    int         m_pkt;

    task automatic drive_up();
        ts_byte_vld = (q.size() > 0);
        ts_byte     = (q.size() > 0) ? q[0][7:0] : 8'h00;
        ts_byte_sop = (q.size() > 0) ? q[0][8] : 1'b0;
    endtask

    task automatic load_pkt(input logic [8:0] first, input int nrest);
        q.push_back(first);
        for (int i = 0; i < nrest; i++) q.push_back({1'b0, 8'($urandom)});
        drive_up();
    endtask

    // Frame as the host sees it: status byte, then packet bytes in order.
    task automatic model_frame(input int nbits, output logic [7:0] want[$],
                               output int left);
        logic [8:0] mq[$];
        logic [8:0] e;
        bit pad;
        int nf;
        mq = q;
        want = {};
        want.push_back({m_und, m_sync, m_abort, mq.size() > 0, 4'(m_pkt)});
        if (nbits > 0) begin
            m_und = 0; m_sync = 0; m_abort = 0;
        end
`ifdef TS_SYNC_CHECK_EN
        if (nbits >= 8) begin
            for (int k = 0; k < 7 && mq.size() > 0 && mq[0] != {1'b1, TS_SYNC}; k++) begin
                void'(mq.pop_front());
                m_sync = 1;
            end
        end
`endif
        nf = nbits / 8;
        if (nf > PL) nf = PL;
        pad = 0;
        for (int k = 1; k <= nf; k++) begin
            if (!pad && mq.size() == 0) begin
                pad = 1; m_und = 1;
            end
            if (pad) begin
                want.push_back(TS_PAD);
            end else begin
                e = mq.pop_front();
                if (k == 1 ? (e != {1'b1, TS_SYNC}) : e[8]) m_sync = 1;
                want.push_back(e[7:0]);
            end
        end
        if (nbits == FULL) begin
            if (!pad) m_pkt++;
        end else if (nbits > 0) begin
            m_abort = 1;
        end
        left = mq.size();
    endtask

    task automatic clk_bits(input int nbits, output logic [7:0] got[$]);
        logic [7:0] sh;
        logic b;
        logic pop;
        got = {};
        sh = '0;
        for (int i = 0; i < nbits; i++) begin
            #5;
            b = spi_miso;
            pop = ts_byte_rdy;
            spi_clk = 1;
            #1;
            if (pop && q.size() > 0) void'(q.pop_front());
            drive_up();
            #4;
            spi_clk = 0;
            sh = {sh[6:0], b};
            if (i % 8 == 7) got.push_back(sh);
        end
    endtask

    task automatic run_frame(input int nbits, output logic [7:0] got[$],
                             output logic [7:0] want[$], output int left);
        model_frame(nbits, want, left);
        spi_cs = 0;
        clk_bits(nbits, got);
        #5 spi_cs = 1;
        #5;
    endtask

    task automatic test_reset();
        reset = 0; spi_cs = 1; spi_clk = 0;
        q.delete(); drive_up();
        m_und = 0; m_sync = 0; m_abort = 0; m_pkt = 0;
        #10;
        checks++;
        if ({spi_miso, spi_miso_oe, ts_byte_rdy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_pins got %b want 000", {spi_miso, spi_miso_oe, ts_byte_rdy});
        end
        checks++;
        if ({pkt_cnt, underrun, sync_err, abort} !== 19'd0) begin
            errors++;
            $display("FAIL reset_state pkt %0d flags %b want 0", pkt_cnt, {underrun, sync_err, abort});
        end
        reset = 1;
        #10;
        checks++;
        if (spi_miso_oe !== 1'b0) begin
            errors++;
            $display("FAIL oe_cs_high got %b want 0", spi_miso_oe);
        end
    endtask

    task automatic test_good();
        logic [7:0] got[$], want[$];
        int left;
        q.push_back({1'b1, TS_SYNC});
        for (int i = 1; i < PL; i++) q.push_back({1'b0, 8'(i)});
        drive_up();
        spi_cs = 0;
        #1;
        checks++;
        if (spi_miso_oe !== 1'b1) begin
            errors++;
            $display("FAIL oe_cs_low got %b want 1", spi_miso_oe);
        end
        run_frame(FULL, got, want, left);
        checks++;
        if (got[0] !== 8'h10) begin
            errors++;
            $display("FAIL good_status got %h want 10", got[0]);
        end
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== want[i]) begin
                errors++;
                $display("FAIL good_byte%0d got %h want %h", i, got[i], want[i]);
            end
        end
        checks++;
        if (pkt_cnt !== 16'd1 || {underrun, sync_err, abort} !== 3'b000) begin
            errors++;
            $display("FAIL good_end pkt %0d flags %b want 1 000", pkt_cnt, {underrun, sync_err, abort});
        end
    endtask

    task automatic test_underrun();
        logic [7:0] got[$], want[$];
        int left;
        q.delete();
        load_pkt({1'b1, TS_SYNC}, 99);
        run_frame(FULL, got, want, left);
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== want[i]) begin
                errors++;
                $display("FAIL under_byte%0d got %h want %h", i, got[i], want[i]);
            end
        end
        checks++;
        if (got[150] !== TS_PAD || underrun !== 1'b1 || pkt_cnt !== 16'(m_pkt)) begin
            errors++;
            $display("FAIL under_end b150 %h und %b pkt %0d want ff 1 %0d", got[150], underrun, pkt_cnt, m_pkt);
        end
        load_pkt({1'b1, TS_SYNC}, PL - 1);
        run_frame(FULL, got, want, left);
        checks++;
        if (got[0][7] !== 1'b1 || got[0] !== want[0]) begin
            errors++;
            $display("FAIL under_status got %h want %h", got[0], want[0]);
        end
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL under_clear got %b want 0", underrun);
        end
    endtask

    task automatic test_sync();
        logic [7:0] got[$], want[$];
        logic [7:0] want1;
        int left;
        q.delete();
`ifdef TS_SYNC_CHECK_EN
        q.push_back({1'b0, 8'h12});
        q.push_back({1'b0, 8'($urandom)});
        q.push_back({1'b0, 8'($urandom)});
        load_pkt({1'b1, TS_SYNC}, 149);
        want1 = TS_SYNC;
`else
        load_pkt({1'b0, 8'h12}, PL - 1);
        want1 = 8'h12;
`endif
        run_frame(FULL, got, want, left);
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== want[i]) begin
                errors++;
                $display("FAIL sync_byte%0d got %h want %h", i, got[i], want[i]);
            end
        end
        checks++;
        if (got[1] !== want1 || sync_err !== 1'b1) begin
            errors++;
            $display("FAIL sync_first got %h err %b want %h 1", got[1], sync_err, want1);
        end
        checks++;
        if (q.size() != left || pkt_cnt !== 16'(m_pkt)) begin
            errors++;
            $display("FAIL sync_fifo left %0d pkt %0d want %0d %0d", q.size(), pkt_cnt, left, m_pkt);
        end
    endtask

    task automatic test_abort();
        logic [7:0] got[$], want[$];
        int left;
        q.delete();
        load_pkt({1'b1, TS_SYNC}, PL - 1);
        model_frame(50 * 8, want, left);
        spi_cs = 0;
        clk_bits(50 * 8, got);
        #5 spi_cs = 1;
        #1;
        checks++;
        if (spi_miso_oe !== 1'b0 || spi_miso !== 1'b0) begin
            errors++;
            $display("FAIL abort_oe got %b %b want 0 0", spi_miso_oe, spi_miso);
        end
        checks++;
        if (abort !== 1'b1 || pkt_cnt !== 16'(m_pkt) || q.size() != left) begin
            errors++;
            $display("FAIL abort_flag got %b pkt %0d left %0d want 1 %0d %0d", abort, pkt_cnt, q.size(), m_pkt, left);
        end
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== want[i]) begin
                errors++;
                $display("FAIL abort_byte%0d got %h want %h", i, got[i], want[i]);
            end
        end
        #4;
        q.delete();
        load_pkt({1'b1, TS_SYNC}, PL - 1);
        run_frame(FULL, got, want, left);
        checks++;
        if (got[0][5] !== 1'b1) begin
            errors++;
            $display("FAIL abort_status got %h want bit5 set", got[0]);
        end
        for (int i = 0; i < got.size(); i++) begin
            checks++;
            if (got[i] !== want[i]) begin
                errors++;
                $display("FAIL abort_next%0d got %h want %h", i, got[i], want[i]);
            end
        end
        checks++;
        if (abort !== 1'b0) begin
            errors++;
            $display("FAIL abort_clear got %b want 0", abort);
        end
    endtask

    task automatic test_mid_reset();
        logic [7:0] got[$], want[$];
        int left;
        q.delete();
        load_pkt({1'b1, TS_SYNC}, PL - 1);
        spi_cs = 0;
        clk_bits(30 * 8 + 3, got);
        #2 reset = 0;
        #1;
        checks++;
        if ({spi_miso, spi_miso_oe, ts_byte_rdy} !== 3'b000 ||
            {pkt_cnt, underrun, sync_err, abort} !== 19'd0) begin
            errors++;
            $display("FAIL midreset pins %b pkt %0d flags %b want 0",
                     {spi_miso, spi_miso_oe, ts_byte_rdy}, pkt_cnt, {underrun, sync_err, abort});
        end
        spi_cs = 1;
        #5 reset = 1;
        m_und = 0; m_sync = 0; m_abort = 0; m_pkt = 0;
        q.delete(); drive_up();
        #5;
        run_frame(8, got, want, left);
        checks++;
        if (got[0] !== 8'h00 || got[0] !== want[0]) begin
            errors++;
            $display("FAIL midreset_status got %h want 00", got[0]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] got[$], want[$];
        int left;
        q.delete();
        for (int f = 0; f < 16; f++) q.push_back({1'b1, TS_SYNC});
        q.delete();
        for (int f = 0; f < 16; f++) begin
            q.push_back({1'b1, TS_SYNC});
            for (int i = 1; i < PL; i++) q.push_back({1'b0, 8'($urandom)});
        end
        drive_up();
        spi_cs = 0;
        for (int f = 0; f < 16; f++) begin
            model_frame(FULL, want, left);
            clk_bits(FULL, got);
            for (int i = 0; i < got.size(); i++) begin
                checks++;
                if (got[i] !== want[i]) begin
                    errors++;
                    $display("FAIL b2b_f%0d_byte%0d got %h want %h", f, i, got[i], want[i]);
                end
            end
        end
        #5 spi_cs = 1;
        #5;
        checks++;
        if (pkt_cnt !== 16'd16) begin
            errors++;
            $display("FAIL b2b_pkt got %0d want 16", pkt_cnt);
        end
        run_frame(8, got, want, left);
        checks++;
        if (got[0][3:0] !== 4'd0 || got[0] !== want[0]) begin
            errors++;
            $display("FAIL b2b_wrap got %h want %h", got[0], want[0]);
        end
    endtask

    initial begin
        test_reset();
        test_good();
        test_underrun();
        test_sync();
        test_abort();
        test_mid_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
